// File: rtl/onehot_picker.sv
// Sequential one-hot source: captures a mask on load and emits its set bits
// lowest-first as a registered one-hot vector under a valid/ready handshake.
module onehot_picker #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [N-1:0]  mask,
  input  logic          ready,
  output logic [N-1:0]  onehot,
  output logic          valid,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  onehot_q,  onehot_d;
  logic          valid_q,   valid_d;
  logic [CW-1:0] count_q,   count_d;

  // Lowest set bit of x; zero in gives zero out.
  function automatic logic [N-1:0] lsb(input logic [N-1:0] x);
    return x & (~x + N'(1));
  endfunction

  always_comb begin
    logic [N-1:0] pend_acc;
    pend_acc  = pending_q & ~onehot_q;
    state_d   = state_q;
    pending_d = pending_q;
    onehot_d  = onehot_q;
    valid_d   = valid_q;
    count_d   = count_q;

    // A load restarts from any state and outranks a simultaneous accept.
    if (load) begin
      count_d = '0;
      if (mask != '0) begin
        pending_d = mask;
        onehot_d  = lsb(mask);
        valid_d   = 1'b1;
        state_d   = EMIT;
      end else begin
        pending_d = '0;
        onehot_d  = '0;
        valid_d   = 1'b0;
        state_d   = DONE;
      end
    end else begin
      case (state_q)
        EMIT: begin
          if (ready) begin
            count_d = count_q + CW'(1);
            if (pend_acc != '0) begin
              pending_d = pend_acc;
              onehot_d  = lsb(pend_acc);
            end else begin
              pending_d = '0;
              onehot_d  = '0;
              valid_d   = 1'b0;
              state_d   = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: begin
          state_d  = IDLE;
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign onehot = onehot_q;
  assign valid  = valid_q;
  assign count  = count_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == EMIT);

endmodule

// File: tb/tb_onehot_picker.sv
// Scoreboard bench for onehot_picker: expected picks are queued on load and
// popped on each accepted handshake; a second N=7 instance covers odd widths.
module tb_onehot_picker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, ready;
  logic [7:0] mask;
  logic [7:0] onehot;
  logic       valid, done, busy;
  logic [3:0] count;

  logic       load7, ready7;
  logic [6:0] mask7, onehot7;
  logic       valid7, done7, busy7;
  logic [3:0] count7;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         exp_count = 0;
  logic       exp_done  = 1'b0;

  always #5 clk = ~clk;

  onehot_picker #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .mask(mask), .ready(ready),
    .onehot(onehot), .valid(valid), .done(done), .count(count), .busy(busy)
  );

  onehot_picker #(.N(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .load(load7), .mask(mask7), .ready(ready7),
    .onehot(onehot7), .valid(valid7), .done(done7), .count(count7), .busy(busy7)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs at the falling edge, then advance the model with the
  // inputs that the coming rising edge will see.
  task automatic step();
    logic [7:0] head;
    @(negedge clk);
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check_val("valid",  32'(valid),  32'(exp_q.size() != 0));
    check_val("busy",   32'(busy),   32'(exp_q.size() != 0));
    check_val("onehot", 32'(onehot), 32'(head));
    check_val("done",   32'(done),   32'(exp_done));
    check_val("count",  32'(count),  32'(exp_count));
    exp_done = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      exp_count = 0;
    end else if (load) begin
      exp_q.delete();
      for (int i = 0; i < 8; i++)
        if (mask[i]) exp_q.push_back(8'(1) << i);
      exp_count = 0;
      exp_done  = (mask == 8'h00);
    end else if (exp_q.size() != 0 && ready) begin
      void'(exp_q.pop_front());
      exp_count++;
      if (exp_q.size() == 0) exp_done = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic r);
    load  = 1'b1;
    mask  = m;
    ready = r;
    step();
    load  = 1'b0;
  endtask

  task automatic run(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      ready = r;
      mask  = 8'($urandom);
      step();
    end
  endtask

  function automatic int idx7(input logic [6:0] v);
    for (int i = 0; i < 7; i++)
      if (v[i]) return i;
    return 7;
  endfunction

  initial begin
    rst_n = 1'b0; load = 1'b0; ready = 1'b0; mask = 8'h00;
    load7 = 1'b0; ready7 = 1'b0; mask7 = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    run(2, 1'b1);

    // Basic sequence, ready held high.
    do_load(8'hA6, 1'b1);
    run(7, 1'b1);

    // Back-pressure pattern 1,0,0,1,...
    do_load(8'hA6, 1'b1);
    for (int i = 0; i < 14; i++) begin
      ready = (i % 3 == 0);
      mask  = 8'($urandom);
      step();
    end

    // Empty mask.
    do_load(8'h00, 1'b1);
    run(3, 1'b1);

    // Restart in EMIT with a simultaneous ready.
    do_load(8'hF0, 1'b1);
    run(1, 1'b1);
    do_load(8'h03, 1'b1);
    run(5, 1'b1);

    // Reset mid-sequence, then normal operation again.
    do_load(8'hFF, 1'b1);
    run(3, 1'b1);
    rst_n = 1'b0;
    run(1, 1'b1);
    rst_n = 1'b1;
    run(2, 1'b0);
    do_load(8'h81, 1'b1);
    run(4, 1'b1);

    // Randomised loads, back-pressure and mid-sequence restarts.
    for (int it = 0; it < 20; it++) begin
      do_load((it % 5 == 0) ? 8'h00 : 8'($urandom), 1'($urandom_range(0, 1)));
      for (int c = 0; c < int'($urandom_range(2, 12)); c++) begin
        ready = 1'($urandom_range(0, 1));
        mask  = 8'($urandom);
        step();
      end
    end
    run(20, 1'b1);

    // N=7 full mask: picks must come out as indices 0..6, one bit at a time.
    load7 = 1'b1; mask7 = 7'h7F; ready7 = 1'b1;
    @(posedge clk);
    #1;
    load7 = 1'b0;
    mask7 = 7'h00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_val("n7_valid", 32'(valid7), 32'd1);
      check_val("n7_index", 32'(idx7(onehot7)), 32'(i));
      check_val("n7_ones",  32'($countones(onehot7)), 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_val("n7_done",  32'(done7),  32'd1);
    check_val("n7_count", 32'(count7), 32'd7);
    check_val("n7_idle",  32'(valid7), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
